// File: rtl/acc_core_mc.sv
// acc_core_mc: multi-cycle accumulator CPU with handshaked instruction and data
// memories, an internal register file, Z/S/CY flags, conditional jumps and HALT.
module acc_core_mc #(
    parameter int DATA_W   = 8,
    parameter int PC_W     = 5,
    parameter int RF_DEPTH = 8,
    parameter int DM_AW    = 10
) (
    input  logic              CLK,
    input  logic              RST,
    output logic              IMEM_REQ,
    output logic [PC_W-1:0]   IMEM_ADDR,
    input  logic              IMEM_ACK,
    input  logic [15:0]       IMEM_DATA,
    output logic              DMEM_REQ,
    output logic              DMEM_WE,
    output logic [DM_AW-1:0]  DMEM_ADDR,
    output logic [DATA_W-1:0] DMEM_WDATA,
    input  logic              DMEM_ACK,
    input  logic [DATA_W-1:0] DMEM_RDATA,
    output logic [DATA_W-1:0] DATA,
    output logic              HALTED
);
    localparam int RF_AW = $clog2(RF_DEPTH);

    typedef enum logic [1:0] {FETCH, EXEC, MEM, HALT} state_t;

    state_t             state;
    state_t             state_next;
    logic [15:0]        ir;
    logic [PC_W-1:0]    pc;
    logic [DATA_W-1:0]  acc;
    logic               flag_z;
    logic               flag_s;
    logic               flag_cy;
    logic [DATA_W-1:0]  rf [RF_DEPTH];

    logic [3:0]         opcode;
    logic [1:0]         mode;
    logic [9:0]         operand;
    logic [RF_AW-1:0]   rf_idx;
    logic               is_alu;
    logic               needs_mem;
    logic               jump_taken;
    logic               alu_commit;
    logic [DATA_W-1:0]  src;
    logic [DATA_W-1:0]  alu_res;
    logic               alu_cy;
    logic [DATA_W:0]    wide;
    logic               imem_req;
    logic               dmem_req;
    logic               halted;

    assign opcode    = ir[15:12];
    assign mode      = ir[11:10];
    assign operand   = ir[9:0];
    assign rf_idx    = operand[RF_AW-1:0];
    assign is_alu    = (opcode >= 4'h1) && (opcode <= 4'h7);
    assign needs_mem = (is_alu && (mode == 2'b10)) || (opcode == 4'h9);

    // An ALU result retires either in EXEC (non-memory source) or when the DM read completes.
    assign alu_commit = is_alu && (((state == EXEC) && (mode != 2'b10)) ||
                                   ((state == MEM) && DMEM_ACK));

    // Source operand: DM read data while in MEM, RF entry for mode 01, otherwise the immediate.
    always_comb begin
        src = DATA_W'(operand);
        if (state == MEM) begin
            src = DMEM_RDATA;
        end else if (mode == 2'b01) begin
            src = rf[rf_idx];
        end
    end

    // ALU: one extra result bit carries the carry-out or, for SUB, the borrow.
    always_comb begin
        wide    = '0;
        alu_res = acc;
        alu_cy  = flag_cy;
        case (opcode)
            4'h1: alu_res = src;
            4'h2: begin
                wide    = {1'b0, acc} + {1'b0, src};
                alu_res = wide[DATA_W-1:0];
                alu_cy  = wide[DATA_W];
            end
            4'h3: begin
                wide    = {1'b0, acc} - {1'b0, src};
                alu_res = wide[DATA_W-1:0];
                alu_cy  = wide[DATA_W];
            end
            4'h4: begin
                alu_res = acc & src;
                alu_cy  = 1'b0;
            end
            4'h5: begin
                alu_res = acc | src;
                alu_cy  = 1'b0;
            end
            4'h6: begin
                alu_res = acc ^ src;
                alu_cy  = 1'b0;
            end
            4'h7: begin
                wide    = {1'b0, acc} + {1'b0, src} + {{DATA_W{1'b0}}, flag_cy};
                alu_res = wide[DATA_W-1:0];
                alu_cy  = wide[DATA_W];
            end
            default: ;
        endcase
    end

    // Branch condition for JMP/JZ/JNZ/JS/JC; any other opcode never jumps.
    always_comb begin
        jump_taken = 1'b0;
        case (opcode)
            4'hA: jump_taken = 1'b1;
            4'hB: jump_taken = flag_z;
            4'hC: jump_taken = ~flag_z;
            4'hD: jump_taken = flag_s;
            4'hE: jump_taken = flag_cy;
            default: ;
        endcase
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake request decode.
    always_comb begin
        state_next = state;
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        halted     = 1'b0;
        case (state)
            FETCH: begin
                imem_req = 1'b1;
                if (IMEM_ACK) begin
                    state_next = EXEC;
                end
            end
            EXEC: begin
                if (opcode == 4'hF) begin
                    state_next = HALT;
                end else if (needs_mem) begin
                    state_next = MEM;
                end else begin
                    state_next = FETCH;
                end
            end
            MEM: begin
                dmem_req = 1'b1;
                if (DMEM_ACK) begin
                    state_next = FETCH;
                end
            end
            HALT: halted = 1'b1;
            default: state_next = FETCH;
        endcase
    end

    // The fetch request is masked while reset is held so it first rises after release.
    assign IMEM_REQ   = imem_req & ~RST;
    assign IMEM_ADDR  = pc;
    assign DMEM_REQ   = dmem_req;
    assign DMEM_WE    = dmem_req && (opcode == 4'h9);
    assign DMEM_ADDR  = operand[DM_AW-1:0];
    assign DMEM_WDATA = acc;
    assign DATA       = acc;
    assign HALTED     = halted;

    // Instruction latch and program counter sequencing; PC wraps naturally at 2^PC_W.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ir <= '0;
            pc <= '0;
        end else begin
            if ((state == FETCH) && IMEM_ACK) begin
                ir <= IMEM_DATA;
            end
            if (state == EXEC) begin
                if (jump_taken) begin
                    pc <= operand[PC_W-1:0];
                end else if ((opcode != 4'hF) && !needs_mem) begin
                    pc <= pc + 1'b1;
                end
            end else if ((state == MEM) && DMEM_ACK) begin
                pc <= pc + 1'b1;
            end
        end
    end

    // Accumulator and flags; Z/S only follow ALU opcodes, CY follows the ALU's own rule.
    always_ff @(posedge CLK) begin
        if (RST) begin
            acc     <= '0;
            flag_z  <= 1'b0;
            flag_s  <= 1'b0;
            flag_cy <= 1'b0;
        end else if (alu_commit) begin
            acc     <= alu_res;
            flag_z  <= (alu_res == '0);
            flag_s  <= alu_res[DATA_W-1];
            flag_cy <= alu_cy;
        end
    end

    // Register file, written only by STR.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < RF_DEPTH; i++) begin
                rf[i] <= '0;
            end
        end else if ((state == EXEC) && (opcode == 4'h8)) begin
            rf[rf_idx] <= acc;
        end
    end

endmodule

// File: tb/tb_acc_core_mc.sv
// tb_acc_core_mc: directed and random programs for acc_core_mc, checked against an
// instruction-level reference model driven by the memory slaves below.
module tb_acc_core_mc;
    localparam int DATA_W   = 8;
    localparam int PC_W     = 5;
    localparam int RF_DEPTH = 8;
    localparam int DM_AW    = 10;

    logic              CLK = 1'b0;
    logic              RST = 1'b1;
    logic              IMEM_REQ;
    logic [PC_W-1:0]   IMEM_ADDR;
    logic              IMEM_ACK = 1'b0;
    logic [15:0]       IMEM_DATA = '0;
    logic              DMEM_REQ;
    logic              DMEM_WE;
    logic [DM_AW-1:0]  DMEM_ADDR;
    logic [DATA_W-1:0] DMEM_WDATA;
    logic              DMEM_ACK = 1'b0;
    logic [DATA_W-1:0] DMEM_RDATA = '0;
    logic [DATA_W-1:0] DATA;
    logic              HALTED;

    acc_core_mc #(.DATA_W(DATA_W), .PC_W(PC_W), .RF_DEPTH(RF_DEPTH), .DM_AW(DM_AW)) dut (
        .CLK(CLK), .RST(RST),
        .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR), .IMEM_ACK(IMEM_ACK), .IMEM_DATA(IMEM_DATA),
        .DMEM_REQ(DMEM_REQ), .DMEM_WE(DMEM_WE), .DMEM_ADDR(DMEM_ADDR), .DMEM_WDATA(DMEM_WDATA),
        .DMEM_ACK(DMEM_ACK), .DMEM_RDATA(DMEM_RDATA), .DATA(DATA), .HALTED(HALTED)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    logic [15:0] imem [32];
    int slave_dm [1024];

    int m_pc, m_acc, m_z, m_s, m_cy, m_halted;
    int m_rf [8];
    int m_dm [1024];
    int exp_dm_valid, exp_dm_addr, exp_dm_we, exp_dm_wdata;

    int i_wait_cfg = 0;
    int d_wait_cfg = 0;
    int i_wait_left, d_wait_left, i_req_len, d_req_len;
    int i_prev_req, i_prev_addr, d_prev_req, d_prev_addr, d_prev_we, d_prev_wdata;
    int fetch_trace [$];
    int i_req_lens [$];
    int d_req_lens [$];
    int exp_trace [$];
    logic force_dack = 1'b0;

    task automatic checkOutput(input string tag, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    function automatic logic [15:0] enc(input int opc, input int mode, input int opr);
        return {opc[3:0], mode[1:0], opr[9:0]};
    endfunction

    function automatic int pickWait(input int cfg);
        return (cfg < 0) ? int'($urandom_range(2, 0)) : cfg;
    endfunction

    // Instruction-level reference: executes one whole instruction with plain integer arithmetic.
    task automatic modelStep(input logic [15:0] ins);
        int opc, mode, opr, src, t, next_pc;
        opc  = int'(ins[15:12]);
        mode = int'(ins[11:10]);
        opr  = int'(ins[9:0]);
        if (mode == 1)      src = m_rf[opr % 8];
        else if (mode == 2) src = m_dm[opr];
        else                src = opr % 256;
        next_pc = (m_pc + 1) % 32;
        case (opc)
            1: m_acc = src;
            2: begin t = m_acc + src; m_cy = (t > 255); m_acc = t % 256; end
            3: begin m_cy = (m_acc < src); m_acc = (m_acc - src + 256) % 256; end
            4: begin m_acc = m_acc & src; m_cy = 0; end
            5: begin m_acc = m_acc | src; m_cy = 0; end
            6: begin m_acc = m_acc ^ src; m_cy = 0; end
            7: begin t = m_acc + src + m_cy; m_cy = (t > 255); m_acc = t % 256; end
            8: m_rf[opr % 8] = m_acc;
            9: begin
                m_dm[opr] = m_acc;
                exp_dm_valid = 1; exp_dm_addr = opr; exp_dm_we = 1; exp_dm_wdata = m_acc;
            end
            10: next_pc = opr % 32;
            11: if (m_z != 0) next_pc = opr % 32;
            12: if (m_z == 0) next_pc = opr % 32;
            13: if (m_s != 0) next_pc = opr % 32;
            14: if (m_cy != 0) next_pc = opr % 32;
            15: begin m_halted = 1; next_pc = m_pc; end
            default: ;
        endcase
        if (opc >= 1 && opc <= 7) begin
            m_z = (m_acc == 0);
            m_s = (m_acc >= 128);
            if (mode == 2) begin
                exp_dm_valid = 1; exp_dm_addr = opr; exp_dm_we = 0;
            end
        end
        m_pc = next_pc;
    endtask

    task automatic resetModel();
        m_pc = 0; m_acc = 0; m_z = 0; m_s = 0; m_cy = 0; m_halted = 0;
        for (int r = 0; r < 8; r++) m_rf[r] = 0;
        m_dm = slave_dm;
        exp_dm_valid = 0;
        i_wait_left = pickWait(i_wait_cfg);
        d_wait_left = pickWait(d_wait_cfg);
        i_req_len = 0; d_req_len = 0;
        i_prev_req = 0; d_prev_req = 0;
        fetch_trace.delete();
        i_req_lens.delete();
        d_req_lens.delete();
    endtask

    // Memory slaves with configurable wait states; every completed handshake is checked
    // against the model, and every fetch advances the model by one instruction.
    always @(negedge CLK) begin : mem_slave
        logic i_ack_now, d_ack_now;
        i_ack_now  = 1'b0;
        d_ack_now  = 1'b0;
        IMEM_DATA  = 16'($urandom);
        DMEM_RDATA = 8'($urandom);
        if (!RST) begin
            if (IMEM_REQ) begin
                if (i_prev_req != 0) checkOutput("imem_addr_stable", int'(IMEM_ADDR), i_prev_addr);
                i_req_len++;
                if (i_wait_left == 0) begin
                    i_ack_now = 1'b1;
                    IMEM_DATA = imem[IMEM_ADDR];
                    fetch_trace.push_back(int'(IMEM_ADDR));
                    i_req_lens.push_back(i_req_len);
                    i_req_len   = 0;
                    i_wait_left = pickWait(i_wait_cfg);
                    checkOutput("fetch_while_halted", m_halted, 0);
                    checkOutput("fetch_pc", int'(IMEM_ADDR), m_pc);
                    checkOutput("data_at_fetch", int'(DATA), m_acc);
                    checkOutput("dmem_done", exp_dm_valid, 0);
                    if (m_halted == 0) modelStep(imem[IMEM_ADDR]);
                end else begin
                    i_wait_left--;
                end
            end
            if (DMEM_REQ) begin
                if (d_prev_req != 0) begin
                    checkOutput("dmem_addr_stable", int'(DMEM_ADDR), d_prev_addr);
                    checkOutput("dmem_we_stable", int'(DMEM_WE), d_prev_we);
                    checkOutput("dmem_wdata_stable", int'(DMEM_WDATA), d_prev_wdata);
                end
                d_req_len++;
                if (d_wait_left == 0) begin
                    d_ack_now = 1'b1;
                    checkOutput("dmem_expected", exp_dm_valid, 1);
                    checkOutput("dmem_addr", int'(DMEM_ADDR), exp_dm_addr);
                    checkOutput("dmem_we", int'(DMEM_WE), exp_dm_we);
                    if (exp_dm_we != 0) checkOutput("dmem_wdata", int'(DMEM_WDATA), exp_dm_wdata);
                    exp_dm_valid = 0;
                    if (DMEM_WE) slave_dm[DMEM_ADDR] = int'(DMEM_WDATA);
                    else DMEM_RDATA = 8'(slave_dm[DMEM_ADDR]);
                    d_req_lens.push_back(d_req_len);
                    d_req_len   = 0;
                    d_wait_left = pickWait(d_wait_cfg);
                end else begin
                    d_wait_left--;
                end
            end
            i_prev_req   = int'(IMEM_REQ && !i_ack_now);
            i_prev_addr  = int'(IMEM_ADDR);
            d_prev_req   = int'(DMEM_REQ && !d_ack_now);
            d_prev_addr  = int'(DMEM_ADDR);
            d_prev_we    = int'(DMEM_WE);
            d_prev_wdata = int'(DMEM_WDATA);
        end
        IMEM_ACK = i_ack_now;
        DMEM_ACK = d_ack_now | force_dack;
    end

    task automatic clearProgram();
        for (int a = 0; a < 32; a++) imem[a] = 16'hF000;
        for (int a = 0; a < 1024; a++) slave_dm[a] = (a * 37) % 256;
    endtask

    task automatic applyReset();
        @(posedge CLK);
        #1 RST = 1'b1;
        resetModel();
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
    endtask

    // Random forward-jumping program, so every run ends in HALT.
    task automatic applyStimulus();
        for (int a = 0; a < 32; a++) begin
            int opc, mode, opr;
            if (a == 31 || $urandom_range(99, 0) < 4) opc = 15;
            else opc = int'($urandom_range(14, 0));
            mode = int'($urandom_range(3, 0));
            opr  = int'($urandom_range(1023, 0));
            if (opc >= 10 && opc <= 14)
                opr = (int'($urandom_range(31, 0)) << 5) | int'($urandom_range(31, a + 1));
            else if (opc == 9 || (opc >= 1 && opc <= 7 && mode == 2))
                opr = int'($urandom_range(15, 0));
            imem[a] = enc(opc, mode, opr);
        end
        for (int a = 0; a < 1024; a++) slave_dm[a] = int'($urandom_range(255, 0));
    endtask

    task automatic waitHalt(input string tag);
        int n;
        n = 0;
        while (!HALTED && n < 3000) begin
            @(negedge CLK);
            n++;
        end
        checkOutput({tag, "_halted"}, int'(HALTED), 1);
        repeat (3) @(negedge CLK);
        checkOutput({tag, "_data"}, int'(DATA), m_acc);
        checkOutput({tag, "_halt_held"}, int'(HALTED), 1);
        checkOutput({tag, "_ireq_idle"}, int'(IMEM_REQ), 0);
        checkOutput({tag, "_dreq_idle"}, int'(DMEM_REQ), 0);
        checkOutput({tag, "_dm_pending"}, exp_dm_valid, 0);
        for (int a = 0; a < 16; a++) checkOutput({tag, "_dm_image"}, slave_dm[a], m_dm[a]);
    endtask

    task automatic checkTrace(input string tag);
        checkOutput({tag, "_trace_len"}, fetch_trace.size(), exp_trace.size());
        for (int k = 0; k < exp_trace.size() && k < fetch_trace.size(); k++)
            checkOutput({tag, "_trace"}, fetch_trace[k], exp_trace[k]);
    endtask

    initial begin : watchdog
        #800000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        clearProgram();
        resetModel();
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        checkOutput("reset_ireq", int'(IMEM_REQ), 0);
        checkOutput("reset_dreq", int'(DMEM_REQ), 0);
        checkOutput("reset_we", int'(DMEM_WE), 0);
        checkOutput("reset_data", int'(DATA), 0);
        checkOutput("reset_halted", int'(HALTED), 0);

        // LD #5; ADD #3; HALT with zero-wait memories, cycle-exact.
        imem[0] = enc(1, 0, 5); imem[1] = enc(2, 0, 3); imem[2] = enc(15, 0, 0);
        applyReset();
        @(negedge CLK);
        checkOutput("first_ireq", int'(IMEM_REQ), 1);
        checkOutput("first_iaddr", int'(IMEM_ADDR), 0);
        repeat (4) @(posedge CLK);
        @(negedge CLK);
        checkOutput("ldadd_data_c4", int'(DATA), 8);
        @(posedge CLK); @(negedge CLK);
        checkOutput("ldadd_halted_c5", int'(HALTED), 0);
        @(posedge CLK); @(negedge CLK);
        checkOutput("ldadd_halted_c6", int'(HALTED), 1);
        waitHalt("ldadd");

        // Carry chain; flags observed through the branch path.
        clearProgram();
        imem[0] = enc(1, 0, 'hFF); imem[1] = enc(2, 0, 1);  imem[2] = enc(14, 0, 4);
        imem[4] = enc(11, 0, 6);   imem[6] = enc(7, 0, 0);  imem[7] = enc(14, 0, 9);
        imem[8] = enc(12, 0, 10);
        applyReset();
        waitHalt("adc");
        checkOutput("adc_data", int'(DATA), 1);
        exp_trace = '{0, 1, 2, 4, 6, 7, 8, 10};
        checkTrace("adc");

        // SUB borrow: JC taken then JS taken.
        clearProgram();
        imem[0] = enc(1, 0, 2); imem[1] = enc(3, 0, 3); imem[2] = enc(14, 0, 7); imem[7] = enc(13, 0, 9);
        applyReset();
        waitHalt("subc");
        checkOutput("subc_data", int'(DATA), 'hFF);
        exp_trace = '{0, 1, 2, 7, 9};
        checkTrace("subc");

        // SUB without borrow: JC falls through.
        imem[1] = enc(3, 0, 1);
        applyReset();
        waitHalt("subnc");
        checkOutput("subnc_data", int'(DATA), 1);
        exp_trace = '{0, 1, 2, 3};
        checkTrace("subnc");

        // STM then DM-sourced ADD with a 3-cycle data wait.
        clearProgram();
        imem[0] = enc(1, 0, 'h5A); imem[1] = enc(9, 0, 'h12); imem[2] = enc(1, 0, 0);
        imem[3] = enc(2, 2, 'h12);
        d_wait_cfg = 3;
        applyReset();
        waitHalt("dmwait");
        checkOutput("dmwait_data", int'(DATA), 'h5A);
        checkOutput("dmwait_written", slave_dm['h12], 'h5A);
        checkOutput("dmwait_count", d_req_lens.size(), 2);
        foreach (d_req_lens[k]) checkOutput("dmwait_req_len", d_req_lens[k], 4);
        d_wait_cfg = 0;

        // STR / RF-sourced ADD with a 2-cycle fetch wait.
        clearProgram();
        imem[0] = enc(1, 0, 9); imem[1] = enc(8, 0, 3); imem[2] = enc(1, 0, 1); imem[3] = enc(2, 1, 3);
        i_wait_cfg = 2;
        applyReset();
        waitHalt("rfwait");
        checkOutput("rfwait_data", int'(DATA), 'h0A);
        checkOutput("rfwait_count", i_req_lens.size(), 5);
        foreach (i_req_lens[k]) checkOutput("rfwait_req_len", i_req_lens[k], 3);
        i_wait_cfg = 0;

        // Reset in the middle of a stalled store, with a late ACK during and after reset.
        clearProgram();
        imem[0] = enc(1, 0, 7); imem[1] = enc(9, 0, 'h20);
        slave_dm['h20] = 'hC3;
        d_wait_cfg = 10;
        applyReset();
        n = 0;
        while (!DMEM_REQ && n < 100) begin
            @(negedge CLK);
            n++;
        end
        checkOutput("rst_mem_reached", int'(DMEM_REQ), 1);
        repeat (2) @(negedge CLK);
        @(posedge CLK);
        #1 RST = 1'b1;
        force_dack = 1'b1;
        d_wait_cfg = 0;
        resetModel();
        @(posedge CLK); @(negedge CLK);
        checkOutput("rst_dreq", int'(DMEM_REQ), 0);
        checkOutput("rst_ireq", int'(IMEM_REQ), 0);
        checkOutput("rst_we", int'(DMEM_WE), 0);
        checkOutput("rst_data", int'(DATA), 0);
        checkOutput("rst_halted", int'(HALTED), 0);
        @(posedge CLK);
        #1 RST = 1'b0;
        checkOutput("rst_no_write", slave_dm['h20], 'hC3);
        @(posedge CLK);
        #1 force_dack = 1'b0;
        waitHalt("rst");
        checkOutput("rst_first_fetch", (fetch_trace.size() > 0) ? fetch_trace[0] : -1, 0);
        checkOutput("rst_data_final", int'(DATA), 7);

        // Random programs with random wait states on both memories.
        i_wait_cfg = -1;
        d_wait_cfg = -1;
        for (int p = 0; p < 10; p++) begin
            applyStimulus();
            applyReset();
            waitHalt("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
